reg_file_sb: RTL and testbench
==============================

# reg_file_sb

32-entry × 32-bit integer register file with a per-register pending-write scoreboard for the RISC-V core. It holds architectural registers x0–x31 and serves two read ports to decode. It takes one write-back port and one issue port. It reports whether each source operand still waits on an in-flight producer, so the pipeline can stall.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; entry count is 2**ADDR_W

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low clears all registers, busy bits and busy_count
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back register index
- wr_data  in  DATA_W  write-back value
- issue_en  in  1  instruction with a destination is issued this cycle
- issue_rd  in  ADDR_W  destination register of the issued instruction
- rs1_addr  in  ADDR_W  read port 1 index
- rs1_data  out  DATA_W  read port 1 value
- rs1_busy  out  1  read port 1 register has a pending write
- rs2_addr  in  ADDR_W  read port 2 index
- rs2_data  out  DATA_W  read port 2 value
- rs2_busy  out  1  read port 2 register has a pending write
- busy_count  out  ADDR_W+1  number of registers currently marked busy

## Operation
- Storage: regs[1..31] are flops. x0 is not stored.
  - Reads of index 0 return 0 with busy 0.
  - Writes to x0 are ignored. Issues to x0 are ignored.
- Write: if wr_en and wr_addr≠0, then regs[wr_addr] ← wr_data at the rising edge.
- Scoreboard: busy[i] updates at each rising edge.
  - Set if issue_en && issue_rd==i, for i≠0.
  - Else cleared if wr_en && wr_addr==i.
  - Else held.
- Simultaneous issue and write to the same register: data is written and busy stays 1. The new producer wins.
- Issue to an already-busy register: busy stays 1 and busy_count is unchanged.
- Write to a non-busy register: data is written and busy_count is unchanged. No error is flagged.
- busy_count is a registered population count of busy[31:1], range 0..31.
  - Per edge it changes by +1, −1 or 0, according to the set/clear events on distinct registers.
- Read ports are combinational from the current state (see Configuration for same-cycle write behaviour).
  - rs1 and rs2 are independent and may address the same register.

## Timing
- Write latency: 1 cycle. A value written at edge N is visible on the read ports after edge N.
- Issue latency: 1 cycle. rsX_busy asserts after the edge that samples issue_en.
- busy_count reflects the state after each edge. It has no combinational path from inputs.
- Reset values while reset is low:
  - All regs = 0, all busy = 0, busy_count = 0.
  - rs1_data = rs2_data = 0, rs1_busy = rs2_busy = 0.
- Reset asserted mid-operation: state clears immediately without waiting for a clock edge. Edges during reset do not update state.
- First update after reset release is at the first rising edge with reset high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wr_en and wr_addr==rsX_addr≠0 in the current cycle, then rsX_data = wr_data.
  - In that same case rsX_busy = 0, unless issue_en && issue_rd==rsX_addr in that same cycle, which has no effect on the current-cycle busy value either way.
  - Effect: write-back data and busy clear are visible in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - rsX_data and rsX_busy come from stored state only.
  - The written value and busy clear appear one cycle later.

## Test plan
- Reset then read: hold reset low, set rs1_addr=5 and rs2_addr=31.
  - Required: rs1_data=rs2_data=0, both busy=0, busy_count=0.
- x0 protection: write 0xFFFFFFFF to x0 and issue x0, then read rs1_addr=0.
  - Required: rs1_data=0, rs1_busy=0, busy_count=0.
- Issue/write-back: issue x7, then after 1 edge check rs1_addr=7. Then write 0x12345678 to x7.
  - After the issue edge: rs1_busy=1, busy_count=1.
  - After the write edge: rs1_data=0x12345678, rs1_busy=0, busy_count=0.
- Same-cycle collision: x3 is busy; issue x3 and write 0xDEADBEEF to x3 in the same cycle.
  - Required after the edge: rs2_data=0xDEADBEEF, rs2_busy=1, busy_count unchanged.
- Bypass: write 0xCAFEF00D to x9 while rs1_addr=9, in the same cycle.
  - With REGFILE_BYPASS_EN: rs1_data=0xCAFEF00D before the edge.
  - Without REGFILE_BYPASS_EN: rs1_data keeps the old value until after the edge.
- Async reset mid-stream: issue x1..x4 (busy_count=4), then drop reset between clock edges.
  - Required: busy_count=0 and all reads 0 immediately, with no clock edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit integer register file with a per-register
// pending-write scoreboard. x0 is hard-wired to zero and never becomes busy.
// This file has two read ports, one write-back port and one issue port.
// Optional feature: define REGFILE_BYPASS_EN so that a write-back is forwarded
// to the read ports in the same cycle, together with its busy clear.
// Without the macro, read ports see stored state only.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs2_busy,
    output logic [ADDR_W:0]   busy_count
);

    localparam int NREG = 1 << ADDR_W;

    // x0 has no storage; the entries run from 1 to NREG-1
    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [NREG-1:1]   busy;
    logic [NREG-1:1]   busy_next;
    logic [ADDR_W:0]   count_next;

    // Architectural register storage; writes to x0 are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Next scoreboard: a new producer (issue) beats a completing one (write-back)
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < NREG; i++) begin
            if (issue_en && (issue_rd == ADDR_W'(i))) begin
                busy_next[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                busy_next[i] = 1'b0;
            end
        end
    end

    // Population count of the next scoreboard, so busy_count is a pure register
    always_comb begin
        count_next = '0;
        for (int i = 1; i < NREG; i++) begin
            count_next = count_next + (ADDR_W + 1)'(busy_next[i]);
        end
    end

    // Scoreboard and its population count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    // Read port 1: x0 reads as zero and idle; optional same-cycle write-back forwarding
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_addr != '0) begin
            rs1_data = regs[rs1_addr];
            rs1_busy = busy[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (reset && wr_en && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
                rs1_busy = 1'b0;
            end
`endif
        end
    end

    // Read port 2: same behaviour as port 1, fully independent of it
    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_addr != '0) begin
            rs2_data = regs[rs2_addr];
            rs2_busy = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (reset && wr_en && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
                rs2_busy = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: directed scenarios plus randomized traffic,
// checked against an array-based reference model of the register file and
// its scoreboard. Honours REGFILE_BYPASS_EN in the expected read values.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic        rs1_busy;
    logic [4:0]  rs2_addr;
    logic [31:0] rs2_data;
    logic        rs2_busy;
    logic [5:0]  busy_count;

    int tests_run;
    int tests_failed;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    reg_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_rd   (issue_rd),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs1_busy   (rs1_busy),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .rs2_busy   (rs2_busy),
        .busy_count (busy_count)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (!reset || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!reset || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return 32'(n);
    endfunction

    function automatic void model_clear();
        foreach (m_regs[i]) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // Reference rule at a clock edge: write-back clears, a later issue re-marks busy
    function automatic void model_edge();
        if (!reset) return;
        if (wr_en && wr_addr != 5'd0) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    endfunction

    task automatic check_all(input string phase);
        checkOutput({phase, " rs1_data"}, rs1_data, exp_data(rs1_addr));
        checkOutput({phase, " rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(rs1_addr)));
        checkOutput({phase, " rs2_data"}, rs2_data, exp_data(rs2_addr));
        checkOutput({phase, " rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(rs2_addr)));
        checkOutput({phase, " busy_count"}, 32'(busy_count), exp_count());
    endtask

    // Drive one cycle of inputs just after a rising edge, check before and after the next edge
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic ie, input logic [4:0] ir,
                                 input logic [4:0] r1, input logic [4:0] r2);
        wr_en = we; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_rd = ir;
        rs1_addr = r1; rs2_addr = r2;
        #1;
        check_all("pre");
        @(posedge clk);
        model_edge();
        #1;
        check_all("post");
    endtask

    initial begin
        logic [4:0] a;
        tests_run = 0;
        tests_failed = 0;
        model_clear();
        reset = 1'b0;
        wr_en = 0; wr_addr = 0; wr_data = 0; issue_en = 0; issue_rd = 0;
        rs1_addr = 5'd5; rs2_addr = 5'd31;

        // Reset held low across edges, with an issue pending: nothing may change
        #2;
        check_all("reset_async");
        issue_en = 1'b1; issue_rd = 5'd6; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        checkOutput("reset_rs1_zero", rs1_data, 32'd0);
        checkOutput("reset_count_zero", 32'(busy_count), 32'd0);
        wr_en = 0; issue_en = 0;
        reset = 1'b1;

        // x0 protection
        applyStimulus(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0, 5'd0);
        checkOutput("x0_data", rs1_data, 32'd0);
        checkOutput("x0_count", 32'(busy_count), 32'd0);

        // Issue then write-back of x7
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0);
        checkOutput("x7_busy_after_issue", 32'(rs1_busy), 32'd1);
        checkOutput("x7_count_after_issue", 32'(busy_count), 32'd1);
        applyStimulus(1, 5'd7, 32'h12345678, 0, 5'd0, 5'd7, 5'd0);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd0);
        checkOutput("x7_data_after_wb", rs1_data, 32'h12345678);
        checkOutput("x7_count_after_wb", 32'(busy_count), 32'd0);

        // Collision on x3: simultaneous issue and write-back keeps it busy
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd3, 5'd0, 5'd3);
        applyStimulus(1, 5'd3, 32'hDEADBEEF, 1, 5'd3, 5'd0, 5'd3);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd3);
        checkOutput("x3_collision_data", rs2_data, 32'hDEADBEEF);
        checkOutput("x3_collision_busy", 32'(rs2_busy), 32'd1);
        checkOutput("x3_collision_count", 32'(busy_count), 32'd1);

        // Issue to an already-busy register and write to an idle one
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd3, 5'd3, 5'd3);
        checkOutput("reissue_count", 32'(busy_count), 32'd1);
        applyStimulus(1, 5'd20, 32'h0BADF00D, 0, 5'd0, 5'd20, 5'd3);
        checkOutput("idle_write_count", 32'(busy_count), 32'd1);

        // Same-cycle read of x9 while it is being written (bypass dependent)
        applyStimulus(1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 5'd9, 5'd9);
        checkOutput("x9_after_edge", rs1_data, 32'hCAFEF00D);

        // Randomized traffic, biased toward a few registers to provoke collisions
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa, ir, r1, r2;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            ir = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? ir : 5'($urandom_range(0, 5));
            applyStimulus(1'($urandom), wa, $urandom, 1'($urandom), ir, r1, r2);
        end

        // Clean restart, then issue x1..x4 and drop reset between edges
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_all("restart");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = 5'(i);
            applyStimulus(0, 5'd0, 32'd0, 1, a, 5'd1, a);
        end
        applyStimulus(1, 5'd2, 32'h77777777, 0, 5'd0, 5'd2, 5'd4);
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd2, 5'd1, 5'd4);
        checkOutput("four_busy_count", 32'(busy_count), 32'd4);
        #2;
        reset = 1'b0;
        model_clear();
        rs1_addr = 5'd2;
        rs2_addr = 5'd4;
        #1;
        checkOutput("midreset_count", 32'(busy_count), 32'd0);
        checkOutput("midreset_rs1_data", rs1_data, 32'd0);
        checkOutput("midreset_rs1_busy", 32'(rs1_busy), 32'd0);
        checkOutput("midreset_rs2_busy", 32'(rs2_busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd4, 5'd4, 5'd2);
        checkOutput("first_after_reset_count", 32'(busy_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
